mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Memory controller between the byte-wide RAM/IO bus and two requesters: the LSB (load/store
//  data) and the instruction fetch unit (word fetch). It serializes each request into byte
//  accesses, assembles and sign-extends read data, and returns a one-cycle ready pulse.
//  It sits directly downstream of the LSB, which consumes mem_ready/mem_val.
// PARAMETERS
//  IO_ADDR_HI  2'b11  addr[17:16] value that marks the IO region; IO writes honour io_buffer_full
// PORTS
//  clk_in          in   1   system clock; single clock domain
//  rst_in          in   1   synchronous, active-high reset
//  rdy_in          in   1   ready; all state frozen while low
//  clear_flag      in   1   pipeline flush (branch mispredict)
//  lsb_req         in   1   LSB request valid (level, held until mem_ready)
//  lsb_addr        in   32  byte address
//  lsb_data        in   32  store data, LSB-aligned
//  lsb_op          in   4   [1:0] size 0=B 1=H 2=W; [2] unsigned load; [3] 1=store
//  mem_ready       out  1   one-cycle pulse: LSB access finished
//  mem_val         out  32  load result, extended per lsb_op; 0 for stores
//  if_req          in   1   fetch request valid (level, held until if_ready)
//  if_addr         in   32  fetch byte address (always a 4-byte read)
//  if_ready        out  1   one-cycle pulse: if_data valid
//  if_data         out  32  fetched instruction, little-endian
//  mem_din         in   8   RAM read byte
//  mem_dout        out  8   RAM write byte
//  mem_a           out  32  RAM byte address
//  mem_wr          out  1   1=write, 0=read
//  io_buffer_full  in   1   IO write buffer full
// BEHAVIOUR
//  Reset: state IDLE; mem_ready=if_ready=0; mem_val=if_data=0; mem_a=0; mem_wr=0; mem_dout=0.
//  States: IDLE, READ, WRITE, DONE.
//   - IDLE->READ/WRITE: on lsb_req or if_req. LSB has priority when both are high.
//     Latch addr, data, op, and N bytes (B=1, H=2, W/fetch=4).
//   - READ/WRITE->DONE: after the last byte completes.
//   - DONE: ready pulse; requests ignored; ->IDLE next cycle.
//  Requesters drop req on the edge that samples ready, so DONE prevents a double accept.
//  Little-endian; RAM read latency is 1 cycle (mem_din at T+1 is the byte addressed at T).
//  Read accepted at cycle T:
//   - mem_a=addr+k, mem_wr=0 at T+1+k (k=0..N-1).
//   - Byte k is captured from mem_din at T+2+k.
//   - Ready pulse at T+N+2. A word read is 6 cycles accept->ready.
//  Write accepted at T:
//   - mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k] at T+1+k.
//   - mem_ready pulse at T+N+1; mem_val=0.
//  IO stall: a write byte with addr[17:16]==IO_ADDR_HI while io_buffer_full=1 is not issued:
//   - mem_wr=0 and mem_a held; retried each cycle; byte counter does not advance.
//  Extension: B/H sign-extend from bit 7/15 unless lsb_op[2]=1 (zero-extend). W unchanged.
//  Outside READ/WRITE: mem_wr=0, mem_a=0, mem_dout=0.
//  rdy_in low:
//   - Everything holds; mem_wr=0.
//   - An in-flight read re-issues the first uncaptured byte address on resume.
//     A byte issued before the pause is never captured.
//  clear_flag:
//   - Aborts an in-flight fetch or load: ->IDLE next cycle, no ready pulse.
//   - An in-flight store writes all remaining bytes, then ->IDLE with no mem_ready pulse.
//     The store is committed; memory must not be torn.
//   - Requests are not accepted in the clear cycle.
//  Reset mid-access: immediate IDLE; remaining bytes dropped.
//  Address arithmetic is 32-bit wrap; no alignment check.
// TESTING
//  1. rst_in 1 cycle -> all outputs 0, state IDLE; no mem_wr for 10 idle cycles.
//  2. Fetch 0x1000, RAM[0x1000..3]=13 05 00 00 -> mem_a 0x1000..0x1003 on T+1..T+4;
//     if_ready pulse at T+6 with if_data=0x00000513.
//  3. RAM[0x20]=0x80 -> LB gives mem_val=0xFFFFFF80; LBU gives 0x00000080 (pulse at T+3).
//  4. SH addr 0x104, data 0xABCD1234 -> mem_wr with (0x104,0x34),(0x105,0x12);
//     mem_ready at T+3; RAM[0x106] untouched.
//  5. lsb_req and if_req both high in the same cycle -> LSB served first.
//     Fetch is accepted the cycle after DONE; if_ready never overlaps mem_ready.
//  6. SB to 0x30000 with io_buffer_full high for 3 cycles -> no write for those cycles,
//     write on the 4th, then mem_ready.
//     clear_flag during a fetch -> no if_ready, IDLE next cycle.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: requester and byte-wide RAM bus signals of the memory controller
interface mem_ctrl_if;
  logic lsb_req;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_data;
  logic [3:0] lsb_op;
  logic mem_ready;
  logic [31:0] mem_val;
  logic if_req;
  logic [31:0] if_addr;
  logic if_ready;
  logic [31:0] if_data;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic [31:0] mem_a;
  logic mem_wr;
  logic io_buffer_full;
  modport master (
    output lsb_req, lsb_addr, lsb_data, lsb_op, if_req, if_addr, mem_din, io_buffer_full,
    input mem_ready, mem_val, if_ready, if_data, mem_dout, mem_a, mem_wr
  );
  modport slave (
    input lsb_req, lsb_addr, lsb_data, lsb_op, if_req, if_addr, mem_din, io_buffer_full,
    output mem_ready, mem_val, if_ready, if_data, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises LSB loads/stores and instruction fetches into byte accesses on the RAM bus
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  input logic clear_flag,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] addr_q, data_q, buf_q, val_q, ifd_q, word, ext;
  logic [2:0] op_q;
  logic [2:0] k, cap, n;
  logic is_if, clr_q, stall, rd_last, wr_last, take_lsb, take_if;
  assign n = is_if || op_q[1] ? 3'd4 : op_q[0] ? 3'd2 : 3'd1;
  assign take_lsb = bus.lsb_req && !clear_flag;
  assign take_if = bus.if_req && !bus.lsb_req && !clear_flag;
  assign stall = bus.mem_a[17:16] == IO_ADDR_HI && bus.io_buffer_full;
  assign rd_last = k > cap && cap + 3'd1 == n;
  assign wr_last = !stall && k + 3'd1 == n;
  assign ext = op_q[1] ? word :
               op_q[0] ? {{16{!op_q[2] && word[15]}}, word[15:0]} :
                         {{24{!op_q[2] && word[7]}}, word[7:0]};
  always_comb begin
    word = buf_q;
    word[{cap[1:0], 3'b000} +: 8] = bus.mem_din;
  end
  assign bus.mem_a = state == READ || state == WRITE ? addr_q + {29'b0, k} : 32'h0;
  assign bus.mem_wr = state == WRITE && rdy_in && !stall;
  assign bus.mem_dout = state == WRITE ? data_q[{k[1:0], 3'b000} +: 8] : 8'h0;
  assign bus.mem_ready = state == DONE && !is_if && rdy_in;
  assign bus.if_ready = state == DONE && is_if && rdy_in;
  assign bus.mem_val = val_q;
  assign bus.if_data = ifd_q;
  always_ff @(posedge clk_in)
    if (rst_in) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (rdy_in)
      case (state)
        IDLE: state_nx = take_lsb ? (bus.lsb_op[3] ? WRITE : READ) : take_if ? READ : IDLE;
        READ: state_nx = clear_flag ? IDLE : rd_last ? DONE : READ;
        WRITE: state_nx = wr_last ? (clr_q || clear_flag ? IDLE : DONE) : WRITE;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk_in)
    if (rst_in) begin
      {addr_q, data_q, buf_q, val_q, ifd_q} <= '0;
      op_q <= '0;
      k <= '0;
      cap <= '0;
      is_if <= 1'b0;
      clr_q <= 1'b0;
    end else if (!rdy_in) begin
      if (state == READ) k <= cap;
    end else if (state == IDLE) begin
      addr_q <= take_lsb ? bus.lsb_addr : bus.if_addr;
      data_q <= bus.lsb_data;
      op_q <= bus.lsb_op[2:0];
      is_if <= !take_lsb;
      clr_q <= 1'b0;
      k <= '0;
      cap <= '0;
    end else if (state == READ) begin
      if (k > cap) begin
        buf_q <= word;
        cap <= cap + 3'd1;
      end
      if (k < n) k <= k + 3'd1;
      if (rd_last && !clear_flag && is_if) ifd_q <= word;
      if (rd_last && !clear_flag && !is_if) val_q <= ext;
    end else if (state == WRITE) begin
      clr_q <= clr_q || clear_flag;
      if (!stall) k <= k + 3'd1;
      if (wr_last) val_q <= '0;
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl against a byte-array memory model
module tb_mem_ctrl;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic clear_flag = 1'b0;
  mem_ctrl_if b();
  mem_ctrl dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag), .bus(b));
  always #5 clk_in = ~clk_in;
  logic [7:0] ram [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [31:0] tr_a [0:15];
  logic tr_wr [0:15];
  logic [7:0] tr_do [0:15];
  int n_chk = 0;
  int n_err = 0;
  function automatic logic [7:0] pat(input int unsigned a);
    if (a == 32'h1000) return 8'h13;
    if (a == 32'h1001) return 8'h05;
    if (a == 32'h1002 || a == 32'h1003) return 8'h00;
    if (a == 32'h20) return 8'h80;
    return 8'(a * 7 + (a >> 5) + 3);
  endfunction
  always @(posedge clk_in)
    if (rst_in) begin
      b.mem_din <= 8'h0;
      for (int i = 0; i < 65536; i++) ram[i] <= pat(i);
    end else begin
      b.mem_din <= ram[b.mem_a[15:0]];
      if (b.mem_wr) ram[b.mem_a[15:0]] <= b.mem_dout;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int nbytes(input logic [3:0] op, input bit fetch);
    return fetch || op[1] ? 4 : op[0] ? 2 : 1;
  endfunction
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [3:0] op, input bit fetch);
    longint v = 0;
    int nb = nbytes(op, fetch);
    for (int i = 0; i < nb; i++) v += longint'(ref_mem[16'(a + i)]) << (8 * i);
    if (!fetch && nb < 4 && !op[2] && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    return 32'(v);
  endfunction
  task automatic ref_reset();
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
  endtask
  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input int nb);
    for (int i = 0; i < nb; i++) ref_mem[16'(a + i)] = d[8 * i +: 8];
  endtask
  function automatic logic [31:0] ram4(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8 * i +: 8] = ram[16'(a + i)];
    return r;
  endfunction
  function automatic logic [31:0] ref4(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8 * i +: 8] = ref_mem[16'(a + i)];
    return r;
  endfunction
  task automatic xact(input bit fetch, input logic [31:0] a, input logic [31:0] d, input logic [3:0] op,
                      input int full_cyc, input int clr_at, input int pause_at, input int pause_len,
                      output logic [31:0] val, output int lat);
    bit got = 0;
    bit other = 0;
    int cyc = 0;
    lat = -1;
    val = 32'h0;
    @(posedge clk_in); #1;
    if (fetch) begin
      b.if_req = 1'b1;
      b.if_addr = a;
    end else begin
      b.lsb_req = 1'b1;
      b.lsb_addr = a;
      b.lsb_data = d;
      b.lsb_op = op;
    end
    while (!got && cyc < 40) begin
      b.io_buffer_full = full_cyc > 0 && cyc <= full_cyc;
      clear_flag = cyc == clr_at;
      rdy_in = !(cyc >= pause_at && cyc < pause_at + pause_len);
      if (cyc == clr_at) begin
        b.lsb_req = 1'b0;
        b.if_req = 1'b0;
      end
      @(negedge clk_in);
      if (cyc < 16) begin
        tr_a[cyc] = b.mem_a;
        tr_wr[cyc] = b.mem_wr;
        tr_do[cyc] = b.mem_dout;
      end
      if (fetch ? b.if_ready : b.mem_ready) begin
        got = 1;
        lat = cyc;
        val = fetch ? b.if_data : b.mem_val;
      end
      if (fetch ? b.mem_ready : b.if_ready) other = 1;
      @(posedge clk_in); #1;
      cyc++;
    end
    b.lsb_req = 1'b0;
    b.if_req = 1'b0;
    clear_flag = 1'b0;
    rdy_in = 1'b1;
    b.io_buffer_full = 1'b0;
    if (got) begin
      @(negedge clk_in);
      chk("pulse_width", fetch ? b.if_ready : b.mem_ready, 32'h0);
    end
    chk("cross_ready", other, 32'h0);
  endtask
  initial begin
    logic [31:0] v, lv, iv;
    int lat, lr, ir;
    bit any_wr, ov;
    b.lsb_req = 1'b0;
    b.lsb_addr = '0;
    b.lsb_data = '0;
    b.lsb_op = '0;
    b.if_req = 1'b0;
    b.if_addr = '0;
    b.io_buffer_full = 1'b0;
    ref_reset();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_mem_ready", b.mem_ready, 0);
    chk("rst_mem_val", b.mem_val, 0);
    chk("rst_if_ready", b.if_ready, 0);
    chk("rst_if_data", b.if_data, 0);
    chk("rst_mem_a", b.mem_a, 0);
    chk("rst_mem_wr", b.mem_wr, 0);
    chk("rst_mem_dout", b.mem_dout, 0);
    any_wr = 0;
    repeat (10) begin
      @(negedge clk_in);
      any_wr |= b.mem_wr;
    end
    chk("idle_no_wr", any_wr, 0);
    @(posedge clk_in); #1;
    b.lsb_req = 1'b1;
    b.lsb_addr = 32'h1000;
    b.lsb_op = 4'b0010;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    b.lsb_req = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("midrst_mem_a", b.mem_a, 0);
    chk("midrst_ready", {b.mem_ready, b.if_ready, b.mem_wr}, 0);
    ref_reset();
    xact(1, 32'h1000, 0, 0, 0, 99, 99, 0, v, lat);
    chk("fetch_data", v, 32'h00000513);
    chk("fetch_lat", lat, 6);
    for (int i = 0; i < 4; i++) chk($sformatf("fetch_a%0d", i), {tr_wr[i + 1], tr_a[i + 1]}, 32'h1000 + i);
    xact(0, 32'h20, 0, 4'b0000, 0, 99, 99, 0, v, lat);
    chk("lb_val", v, 32'hFFFFFF80);
    chk("lb_lat", lat, 3);
    xact(0, 32'h20, 0, 4'b0100, 0, 99, 99, 0, v, lat);
    chk("lbu_val", v, 32'h00000080);
    chk("lbu_lat", lat, 3);
    xact(0, 32'h104, 32'hABCD1234, 4'b1001, 0, 99, 99, 0, v, lat);
    chk("sh_lat", lat, 3);
    chk("sh_val", v, 0);
    chk("sh_b0", {tr_wr[1], tr_a[1][15:0], tr_do[1]}, {1'b1, 16'h0104, 8'h34});
    chk("sh_b1", {tr_wr[2], tr_a[2][15:0], tr_do[2]}, {1'b1, 16'h0105, 8'h12});
    chk("sh_done_no_wr", tr_wr[3], 0);
    chk("sh_untouched", ram[16'h106], pat(32'h106));
    ref_store(32'h104, 32'hABCD1234, 2);
    chk("sh_mem", ram4(32'h104), ref4(32'h104));
    @(posedge clk_in); #1;
    b.lsb_req = 1'b1;
    b.lsb_addr = 32'h20;
    b.lsb_op = 4'b0100;
    b.if_req = 1'b1;
    b.if_addr = 32'h1000;
    lr = -1;
    ir = -1;
    ov = 0;
    lv = 0;
    iv = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if (b.mem_ready) begin
        lr = c;
        lv = b.mem_val;
      end
      if (b.if_ready) begin
        ir = c;
        iv = b.if_data;
      end
      ov |= b.mem_ready & b.if_ready;
      @(posedge clk_in); #1;
      if (lr == c) b.lsb_req = 1'b0;
      if (ir == c) b.if_req = 1'b0;
    end
    chk("both_lsb_first", lr, 3);
    chk("both_lsb_val", lv, 32'h80);
    chk("both_if_after", ir, 10);
    chk("both_if_data", iv, 32'h00000513);
    chk("both_no_overlap", ov, 0);
    xact(0, 32'h30000, 32'h5A, 4'b1000, 3, 99, 99, 0, v, lat);
    chk("io_stall_wr", {tr_wr[1], tr_wr[2], tr_wr[3]}, 0);
    chk("io_stall_a", tr_a[2], 32'h30000);
    chk("io_write", {tr_wr[4], tr_a[4], tr_do[4]}, {1'b1, 32'h30000, 8'h5A});
    chk("io_lat", lat, 5);
    ref_store(32'h30000, 32'h5A, 1);
    chk("io_mem", ram[0], 8'h5A);
    xact(1, 32'h2000, 0, 0, 0, 2, 99, 0, v, lat);
    chk("clr_fetch_noready", lat, -1);
    chk("clr_fetch_idle", tr_a[3], 0);
    xact(0, 32'h400, 32'hDEADBEEF, 4'b1010, 0, 2, 99, 0, v, lat);
    chk("clr_store_noready", lat, -1);
    chk("clr_store_mem", ram4(32'h400), 32'hDEADBEEF);
    ref_store(32'h400, 32'hDEADBEEF, 4);
    xact(0, 32'h600, 0, 4'b0010, 0, 99, 3, 2, v, lat);
    chk("pause_load", v, exp_load(32'h600, 4'b0010, 0));
    xact(0, 32'hFFFFFFFE, 0, 4'b0010, 0, 99, 99, 0, v, lat);
    chk("wrap_val", v, exp_load(32'hFFFFFFFE, 4'b0010, 0));
    chk("wrap_a", tr_a[3], 0);
    for (int it = 0; it < 150; it++) begin
      bit fe, st, io;
      int nb, full, clr, pa, pl;
      logic [3:0] op;
      logic [31:0] a, d, e;
      fe = $urandom_range(0, 9) < 3;
      st = !fe && $urandom_range(0, 1) == 1;
      op = {st, 1'($urandom), 2'($urandom_range(0, 2))};
      nb = nbytes(op, fe);
      io = $urandom_range(0, 3) == 0;
      a = $urandom;
      a[15:0] = 16'($urandom_range(0, 16'hFFEF));
      a[17:16] = io ? 2'b11 : 2'($urandom_range(0, 2));
      d = $urandom;
      full = $urandom_range(0, 3);
      clr = $urandom_range(0, 7) == 0 ? $urandom_range(1, nb) : 99;
      pa = clr == 99 && $urandom_range(0, 7) == 0 ? $urandom_range(0, 4) : 99;
      pl = $urandom_range(1, 3);
      e = st ? 32'h0 : exp_load(a, op, fe);
      xact(fe, a, d, op, full, clr, pa, pl, v, lat);
      if (clr != 99) chk("rnd_clr_noready", lat, -1);
      else begin
        chk("rnd_val", v, e);
        if (pa == 99) chk("rnd_lat", lat, st ? nb + 1 + (io ? full : 0) : nb + 2);
      end
      if (st) begin
        ref_store(a, d, nb);
        chk("rnd_mem", ram4(a), ref4(a));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
